regfile: RTL

General-purpose register file for the MIPS core: 32 registers, one synchronous write port, two combinational read ports. The decode stage reads operands from it and the write-back stage writes results into it. The write side demultiplexes one write-back value onto one of 32 registers. The read side selects one register per port. Register $0 is hard-wired to zero. Same-cycle write-to-read bypass is built in, so decode sees the value being written back in that cycle.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_wdec.sv | 21 ++
 rtl/regfile.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS general-purpose register file and its write decoder.
package regfile_pkg;

  localparam int unsigned WIDTH_DATA_DEFAULT = 32;
  localparam int unsigned NUM_REGS_DEFAULT   = 32;
  localparam int unsigned WIDTH_ADDR_DEFAULT = 5;

  // Architectural register indices
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

endpackage : regfile_pkg

// File: rtl/regfile_wdec.sv
// One-hot write-enable decoder for indexed write targets; index 0 never decodes.
module regfile_wdec
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR = WIDTH_ADDR_DEFAULT,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT
) (
  input  logic                  en,
  input  logic [WIDTH_ADDR-1:0] addr,
  output logic [NUM_REGS-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    onehot[REG_ZERO] = 1'b0;
  end

endmodule : regfile_wdec

// File: rtl/regfile.sv
// 32-entry register file: one byte-strobed synchronous write port, two
// combinational read ports with same-cycle write-to-read bypass, $0 tied to zero.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEFAULT,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int unsigned WIDTH_ADDR = WIDTH_ADDR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [WIDTH_ADDR-1:0]   waddr,
  input  logic [WIDTH_DATA-1:0]   wdata,
  input  logic [WIDTH_DATA/8-1:0] wstrb,
  input  logic [WIDTH_ADDR-1:0]   raddr1,
  input  logic [WIDTH_ADDR-1:0]   raddr2,
  output logic [WIDTH_DATA-1:0]   rdata1,
  output logic [WIDTH_DATA-1:0]   rdata2
);

  localparam int unsigned NUM_BYTES = WIDTH_DATA / 8;
  localparam logic [WIDTH_ADDR-1:0] ADDR_ZERO = WIDTH_ADDR'(REG_ZERO);

  logic [WIDTH_DATA-1:0] regs_q [NUM_REGS];
  logic [WIDTH_DATA-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wen;
  logic [WIDTH_DATA-1:0] wmerge;

  regfile_wdec #(
    .WIDTH_ADDR (WIDTH_ADDR),
    .NUM_REGS   (NUM_REGS)
  ) u_wdec (
    .en     (we & ~rst),
    .addr   (waddr),
    .onehot (wen)
  );

  // Strobe merge of write data over the currently stored value; shared by store and bypass
  always_comb begin
    wmerge = regs_q[waddr];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wstrb[b]) begin
        wmerge[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = wen[r] ? wmerge : regs_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // wen[raddr] is set only when a live write targets this nonzero index, so it selects the bypass
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (!rst) begin
      if (raddr1 != ADDR_ZERO) begin
        rdata1 = wen[raddr1] ? wmerge : regs_q[raddr1];
      end
      if (raddr2 != ADDR_ZERO) begin
        rdata2 = wen[raddr2] ? wmerge : regs_q[raddr2];
      end
    end
  end

endmodule : regfile
